nand_id_sequencer: RTL and testbench

- Autonomous command sequencer in front of nand_master's host command interface (cmd_in/data_in/activate/busy/data_out).
- On a single start pulse it runs: chip enable, READ ID, fetch ID_BYTES bytes, chip disable.
- Presents the assembled ID word with valid/error status.
- Used for boot-time device identification without CPU involvement; the sequencer owns the nand_master command port while busy.

---
 rtl/nand_id_sequencer.sv | 132 +++++++++++++
 tb/tb_nand_id_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_id_sequencer.sv
// nand_id_sequencer: autonomous chip-enable / READ ID / byte fetch / chip-disable sequencer for nand_master
module nand_id_sequencer #(
  parameter int ID_BYTES = 5,
  parameter logic [7:0] ID_ADDR = 8'h00,
  parameter logic [7:0] CMD_ENABLE = 8'h09,
  parameter logic [7:0] CMD_READ_ID = 8'h03,
  parameter logic [7:0] CMD_GET_BYTE = 8'h0e,
  parameter logic [7:0] CMD_DISABLE = 8'h08,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic nreset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  output logic id_valid,
  output logic [8*ID_BYTES-1:0] id_out,
  output logic [7:0] nm_cmd,
  output logic [7:0] nm_data_in,
  output logic nm_activate,
  input  logic nm_busy,
  input  logic [7:0] nm_data_out
);
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, NEXT, FINISH} state_t;
  localparam logic [3:0] LAST = 4'(ID_BYTES + 2);
  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] step_q, step_d, nstep, idx;
  logic [15:0] cnt_q, cnt_d;
  logic busy_q, busy_d, err_q, err_d, val_q, val_d, tout, last, abort;
  logic [8*ID_BYTES-1:0] id_q, id_d;
  logic [7:0] cmd_q, cmd_d, din_q, din_d;
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    err_d = err_q;
    val_d = val_q;
    id_d = id_q;
    cmd_d = cmd_q;
    din_d = din_q;
    nm_activate = 1'b0;
    abort = 1'b0;
    last = step_q == LAST;
    tout = cnt_q == TLIM;
    nstep = step_q + 4'd1;
    idx = step_q - 4'd2;
    if (state_q inside {ISSUE, SETTLE, WAIT}) cnt_d = cnt_q + 16'd1;
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
        err_d = 1'b0;
        val_d = 1'b0;
        id_d = '0;
        step_d = 4'd0;
        cnt_d = 16'd0;
        cmd_d = CMD_ENABLE;
        din_d = 8'h00;
        state_d = ISSUE;
      end
      ISSUE: if (!nm_busy) begin
        nm_activate = 1'b1;
        state_d = SETTLE;
      end else abort = tout;
      SETTLE: begin
        state_d = WAIT;
        abort = tout;
      end
      WAIT: if (!nm_busy) begin
        if (!last && step_q >= 4'd2) id_d[{idx, 3'b000} +: 8] = nm_data_out;
        state_d = NEXT;
      end else abort = tout;
      NEXT: if (last) state_d = FINISH;
      else begin
        step_d = nstep;
        cnt_d = 16'd0;
        cmd_d = nstep == LAST ? CMD_DISABLE : nstep == 4'd1 ? CMD_READ_ID : CMD_GET_BYTE;
        din_d = nstep == 4'd1 ? ID_ADDR : 8'h00;
        state_d = ISSUE;
      end
      FINISH: begin
        busy_d = 1'b0;
        val_d = ~err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      if (last) state_d = FINISH;
      else begin
        err_d = 1'b1;
        step_d = LAST;
        cnt_d = 16'd0;
        cmd_d = CMD_DISABLE;
        din_d = 8'h00;
        state_d = ISSUE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      step_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      val_q <= 1'b0;
      id_q <= '0;
      cmd_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      err_q <= err_d;
      val_q <= val_d;
      id_q <= id_d;
      cmd_q <= cmd_d;
      din_q <= din_d;
    end
  end
  assign busy = busy_q;
  assign done = state_q == FINISH;
  assign error = err_q;
  assign id_valid = val_q;
  assign id_out = id_q;
  assign nm_cmd = cmd_q;
  assign nm_data_in = din_q;
endmodule

// File: tb/tb_nand_id_sequencer.sv
// tb_nand_id_sequencer: directed bench with a nand_master bus-functional model
module tb_nand_id_sequencer;
  logic clk = 0, nreset = 0, start = 0, start_t = 0, nm_busy, sel_t = 0;
  logic [7:0] nm_data_out;
  logic busy, done, error, id_valid, nm_activate;
  logic [39:0] id_out;
  logic [7:0] nm_cmd, nm_data_in;
  logic busy_t, done_t, error_t, id_valid_t, act_t;
  logic [39:0] id_out_t;
  logic [7:0] cmd_t, din_t;
  int tests = 0, fails = 0;
  int lat = 3, left = 0, bi = 0, done_cnt = 0;
  bit hold = 0, stick = 0, ext = 0;
  logic [7:0] lc[$], ld[$];
  logic [7:0] bytes [5] = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86};
  typedef struct {logic [7:0] cmd; logic [7:0] din;} vec_t;
  vec_t exp_nom [8];

  always #5 clk = ~clk;

  nand_id_sequencer dut (
    .clk(clk), .nreset(nreset), .start(start), .busy(busy), .done(done), .error(error),
    .id_valid(id_valid), .id_out(id_out), .nm_cmd(nm_cmd), .nm_data_in(nm_data_in),
    .nm_activate(nm_activate), .nm_busy(nm_busy), .nm_data_out(nm_data_out)
  );
  nand_id_sequencer #(.TIMEOUT_CYCLES(16), .ID_ADDR(8'h90)) dut_t (
    .clk(clk), .nreset(nreset), .start(start_t), .busy(busy_t), .done(done_t), .error(error_t),
    .id_valid(id_valid_t), .id_out(id_out_t), .nm_cmd(cmd_t), .nm_data_in(din_t),
    .nm_activate(act_t), .nm_busy(nm_busy), .nm_data_out(nm_data_out)
  );

  initial begin
    logic a;
    logic [7:0] c, d;
    nm_busy = 0;
    nm_data_out = 0;
    forever begin
      @(negedge clk);
      a = sel_t ? act_t : nm_activate;
      c = sel_t ? cmd_t : nm_cmd;
      d = sel_t ? din_t : nm_data_in;
      if (a) begin
        lc.push_back(c);
        ld.push_back(d);
      end
      if (sel_t ? done_t : done) done_cnt++;
      @(posedge clk);
      #1;
      if (left > 0) left--;
      if (a) begin
        left = lat;
        if (c == 8'h0e && bi < 5) begin
          nm_data_out = bytes[bi];
          bi++;
        end
        if (c == 8'h03 && stick) hold = 1;
      end
      nm_busy = hold || ext || left > 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    if (sel_t) start_t = 1;
    else start = 1;
    @(posedge clk);
    #1;
    start = 0;
    start_t = 0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sel_t ? done_t : done) && n < maxc);
    if (!(sel_t ? done_t : done)) chk("done_bound", 0, 1);
  endtask

  task automatic clear();
    repeat (6) @(negedge clk);
    lc.delete();
    ld.delete();
    bi = 0;
    done_cnt = 0;
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_act_count"}, lc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), lc[i], exp_nom[i].cmd);
      chk($sformatf("%s_din%0d", tag, i), ld[i], exp_nom[i].din);
    end
    chk({tag, "_id_out"}, id_out, 40'h8603FFE52C);
    chk({tag, "_id_valid"}, id_valid, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n, k;
    bit seen;
    exp_nom = '{'{8'h09, 8'h00}, '{8'h03, 8'h00}, '{8'h0e, 8'h00}, '{8'h0e, 8'h00},
                '{8'h0e, 8'h00}, '{8'h0e, 8'h00}, '{8'h0e, 8'h00}, '{8'h08, 8'h00}};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy, done, error, id_valid, nm_activate, nm_cmd, nm_data_in, id_out}, 0);
    chk("reset_outs_t", {busy_t, done_t, error_t, id_valid_t, act_t, cmd_t, din_t, id_out_t}, 0);
    nreset = 1;
    clear();

    pulse();
    chk("nom_busy", busy, 1);
    wait_done(500, n);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("nom_done_cnt", done_cnt, 1);
    check_nominal("nom");

    clear();
    lat = 0;
    pulse();
    chk("zl_valid_cleared", id_valid, 0);
    wait_done(500, n);
    chk("zl_latency", n + 1, 33);
    @(posedge clk);
    #1;
    check_nominal("zl");
    lat = 3;

    clear();
    pulse();
    repeat (10) @(posedge clk);
    #1;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    wait_done(500, n);
    repeat (5) @(negedge clk);
    chk("sb_done_cnt", done_cnt, 1);
    check_nominal("sb");

    clear();
    pulse();
    k = 0;
    while (lc.size() < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_getbyte", lc.size() >= 4, 1);
    repeat (2) @(negedge clk);
    #1;
    nreset = 0;
    @(posedge clk);
    #1;
    nreset = 1;
    chk("rst_mid_outs", {busy, done, error, id_valid, nm_activate, nm_cmd, nm_data_in, id_out}, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= nm_activate;
    end
    chk("rst_no_activate", seen, 0);
    clear();
    pulse();
    wait_done(500, n);
    @(posedge clk);
    #1;
    check_nominal("rerun");

    clear();
    ext = 1;
    pulse();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= nm_activate;
    end
    ext = 0;
    chk("pb_no_early_act", seen, 0);
    @(negedge clk);
    chk("pb_act_on_drop", {nm_busy, nm_activate, nm_cmd}, {1'b0, 1'b1, 8'h09});
    wait_done(500, n);
    @(posedge clk);
    #1;
    chk("pb_error", error, 0);
    chk("pb_valid", id_valid, 1);
    chk("pb_id", id_out, 40'h8603FFE52C);

    clear();
    sel_t = 1;
    stick = 1;
    pulse();
    k = 0;
    while (!hold && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_stuck", hold, 1);
    repeat (20) @(negedge clk);
    hold = 0;
    wait_done(300, n);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("toA_act_count", lc.size(), 3);
    chk("toA_cmd0", lc[0], 8'h09);
    chk("toA_cmd1", {lc[1], ld[1]}, 16'h0390);
    chk("toA_cmd2", lc[2], 8'h08);
    chk("toA_error", error_t, 1);
    chk("toA_valid", id_valid_t, 0);
    chk("toA_id", id_out_t, 0);
    chk("toA_done_cnt", done_cnt, 1);

    clear();
    pulse();
    chk("toB_err_cleared", error_t, 0);
    wait_done(300, n);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("toB_act_count", lc.size(), 2);
    seen = 0;
    foreach (lc[i]) seen |= (lc[i] == 8'h08 || lc[i] == 8'h0e);
    chk("toB_no_0e_08", seen, 0);
    chk("toB_error", error_t, 1);
    chk("toB_valid", id_valid_t, 0);
    chk("toB_id", id_out_t, 0);
    chk("toB_done_cnt", done_cnt, 1);
    hold = 0;
    stick = 0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
